// File: rtl/residue_err_monitor.sv
// Mod-3 residue comparison monitor: 2-stage check pipeline, saturating mismatch
// counters and a RUN/DEGRADED/FAIL health FSM. Optional fault injection: RESIDUE_MON_FI_EN.
module residue_err_monitor #(
  parameter int CNT_W       = 8,
  parameter int WARN_TH     = 4,
  parameter int FAIL_CONSEC = 3,
  parameter int NG          = 128,
  parameter int GID_BASE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       r_meas,
  input  logic [1:0]       r_pred,
  input  logic             clear,
  output logic             out_valid,
  output logic             out_ok,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state,
  output logic             alarm
`ifdef RESIDUE_MON_FI_EN
  ,
  input  logic [NG-1:0]    fault_en_bus,
  input  logic             fault_val
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAIL     = 2'b10
  } state_t;

  localparam int               CONS_W   = $clog2(FAIL_CONSEC + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(FAIL_CONSEC);
  localparam logic [CNT_W-1:0]  WARN_V   = CNT_W'(WARN_TH);
  localparam logic [CNT_W-1:0]  ERR_MAX  = '1;

  if (GID_BASE < 0 || GID_BASE + 2 > NG) begin : g_gid_range
    $error("residue_err_monitor: gate IDs GID_BASE..GID_BASE+1 must lie inside fault_en_bus");
  end

  function automatic logic [1:0] norm(input logic [1:0] r);
    return (r == 2'b11) ? 2'b00 : r;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CONS_W-1:0] consec_q, consec_d;
  logic              s1_valid;
  logic [1:0]        s1_meas, s1_pred;
  logic              mismatch_raw, mismatch, ok_raw, ok_d;
  logic              accept;

  assign in_ready = (state_q != ST_FAIL);
  assign accept   = in_valid && in_ready;

  assign mismatch_raw = (s1_meas != s1_pred);
`ifdef RESIDUE_MON_FI_EN
  assign mismatch = fault_en_bus[GID_BASE]     ? fault_val : mismatch_raw;
  assign ok_raw   = !mismatch;
  assign ok_d     = fault_en_bus[GID_BASE + 1] ? fault_val : ok_raw;
`else
  assign mismatch = mismatch_raw;
  assign ok_raw   = !mismatch;
  assign ok_d     = ok_raw;
`endif

  // Counters and FSM see the result at the same edge that registers out_valid.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    err_d    = err_q;
    consec_d = consec_q;
    state_d  = state_q;
    if (s1_valid) begin
      if (!ok_d) begin
        if (err_q != ERR_MAX)     err_d    = err_q + CNT_W'(1);
        if (consec_q != CONS_MAX) consec_d = consec_q + CONS_W'(1);
      end else begin
        consec_d = '0;
      end
    end
    if (state_q != ST_FAIL) begin
      if (consec_d >= CONS_MAX)   state_d = ST_FAIL;
      else if (err_d >= WARN_V)   state_d = ST_DEGRADED;
    end
    if (clear) begin
      err_d    = '0;
      consec_d = '0;
      state_d  = ST_RUN;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      err_q     <= '0;
      consec_q  <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_ok    <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      consec_q  <= consec_d;
      s1_valid  <= accept;
      out_valid <= s1_valid;
      out_ok    <= s1_valid && ok_d;
    end
  end

  // NOTE: stage-1 residues are qualified by s1_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_meas <= norm(r_meas);
      s1_pred <= norm(r_pred);
    end
  end

  assign err_cnt = err_q;
  assign state   = state_q;
  assign alarm   = (state_q == ST_FAIL);

endmodule

// File: doc/residue_err_monitor.md
Name: residue_err_monitor

Overview:
- Downstream consumer of the mod-3 residue generator: compares the measured 2-bit residue against the residue predicted by the arithmetic checking path.
- Pipelines the comparison, counts mismatches and runs a health FSM (RUN/DEGRADED/FAIL).
- Reports per-word check results and a sticky alarm to the fault-campaign harness.

Parameters:
- CNT_W, 8, width of saturating mismatch counter err_cnt
- WARN_TH, 4, total mismatches at/above which state goes DEGRADED
- FAIL_CONSEC, 3, consecutive mismatching words that force FAIL
- NG, 128, width of fault_en_bus (fault feature only)
- GID_BASE, 0, first gate ID used by this block (fault feature only)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  r_meas/r_pred valid this cycle
- in_ready  out  1  block accepts a word; 0 only in FAIL
- r_meas  in  2  residue from residue generator (2'b11 is a legal encoding, ≡0)
- r_pred  in  2  predicted residue (same encoding)
- clear  in  1  synchronous clear of counters/state, no reset needed
- out_valid  out  1  check result valid
- out_ok  out  1  1 = residues congruent mod 3
- err_cnt  out  CNT_W  saturating total mismatch count
- state  out  2  00 RUN, 01 DEGRADED, 10 FAIL
- alarm  out  1  sticky, 1 while state==FAIL

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_ok=0, err_cnt=0, consecutive counter=0, state=RUN, alarm=0, in_ready=1, pipeline valids cleared. Reset mid-operation discards in-flight words.
- Transfer occurs when in_valid && in_ready.
- Normalise: value 2'b11 maps to 0 before comparison; the mismatch signal is normalised r_meas != normalised r_pred.
- Stage 1 registers the normalised residues and valid. Stage 2 registers out_ok/out_valid; latency is 2 cycles from accepted word to out_valid. Throughput is 1 word/cycle, with no backpressure from the output.
- On each stage-2 result:
  - Mismatch: err_cnt += 1 (saturate at 2^CNT_W-1) and consec += 1 (saturate at FAIL_CONSEC).
  - Match: consec = 0.
- Counters and state are updated in the same cycle that out_valid rises.
- FSM, evaluated on updated values:
  - RUN -> DEGRADED when err_cnt >= WARN_TH.
  - RUN/DEGRADED -> FAIL when consec >= FAIL_CONSEC; FAIL has priority over DEGRADED.
  - DEGRADED never returns to RUN except via clear or reset.
  - FAIL is terminal until clear or reset.
- FAIL: in_ready=0 and alarm=1. Words already in the pipeline still complete and are counted, but cannot change the state.
- clear=1: same effect as reset on counters, state, alarm and in_ready, next cycle. Pipeline contents are preserved; a result arriving in the same cycle as clear is discarded from the counts.
- in_valid while in_ready=0: ignored, not stored.

Optional Feature:
- Macro RESIDUE_MON_FI_EN.
- When defined:
  - Ports fault_en_bus[NG-1:0] and fault_val are added.
  - The mismatch signal uses gate ID GID_BASE+0, and the stage-2 out_ok input uses GID_BASE+1.
  - If the corresponding fault_en_bus bit is 1, that signal is replaced by fault_val.
  - Counters and FSM observe the faulted value.
- When undefined: no extra ports, no gate IDs consumed, behaviour as above.

Test Plan:
- Reset, then words (r_meas, r_pred) = (1,1), (2,2), (3,0) -> out_valid 2 cycles after each, out_ok=1 for all, err_cnt=0, state=RUN.
- Words (1,2), (0,1), (2,1), (1,0), each separated by a match -> err_cnt=4, state=DEGRADED after the 4th, alarm=0, in_ready=1.
- Three consecutive mismatches (1,2) x3 -> state=FAIL on the 3rd result, alarm=1, in_ready=0; further in_valid is ignored.
- In FAIL, assert clear -> next cycle state=RUN, err_cnt=0, alarm=0, in_ready=1.
- Send 300 mismatching words with clear pulsed every 2 words, CNT_W=8 -> err_cnt never exceeds 2; separately force consec-free mismatches past 255 with FAIL_CONSEC large -> err_cnt holds at 255.
- RESIDUE_MON_FI_EN defined, fault_en_bus[GID_BASE+0]=1, fault_val=1, matching inputs (2,2) -> out_ok=0, err_cnt increments; fault_en_bus=0 -> out_ok=1.
